// File: rtl/mips_muldiv_unit_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply-divide unit.
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             flush;
  logic             hilo_read;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, flush, hilo_read,
    input  busy, done, div_by_zero, stall, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, flush, hilo_read,
    output busy, done, div_by_zero, stall, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// Operands are reduced to magnitudes, WIDTH radix-2 steps run on a shared
// 2*WIDTH accumulator, and one FIXUP cycle restores signs before commit.
module mips_muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter bit DIV_EN = 1'b1
) (
  input logic               clk,
  input logic               reset,
  mips_muldiv_unit_if.slave bus
);
  localparam int COUNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r, state_n;
  logic [2*WIDTH-1:0]   acc_r;
  logic [WIDTH-1:0]     b_r;
  logic [WIDTH-1:0]     a_raw_r;
  logic [COUNT_W-1:0]   count_r;
  logic                 is_div_r, neg_res_r, neg_rem_r, dbz_flag_r;
  logic [WIDTH-1:0]     hi_r, lo_r;
  logic                 busy_r, done_r, dbz_out_r;

  logic                 start_op_s, signed_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0]     a_abs_s, b_abs_s;
  logic [WIDTH:0]       mul_add_s, div_trial_s, div_diff_s;
  logic                 div_ge_s;
  logic [2*WIDTH-1:0]   step_acc_s, prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s;

  // Two's-complement negate when the flag is set.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Decode the incoming request and form operand magnitudes.
  always_comb begin
    start_op_s = bus.start & ~bus.flush & (state_r == IDLE) & (bus.op <= 3'd3);
    signed_s   = ~bus.op[0];
    a_neg_s    = signed_s & bus.rs_data[WIDTH-1];
    b_neg_s    = signed_s & bus.rt_data[WIDTH-1];
    a_abs_s    = neg_if(bus.rs_data, a_neg_s);
    b_abs_s    = neg_if(bus.rt_data, b_neg_s);
  end

  // One iteration: shift-add for multiply, restoring subtract-shift for divide.
  always_comb begin
    mul_add_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s  = div_trial_s - {1'b0, b_r};
    div_ge_s    = ~div_diff_s[WIDTH];
    if (is_div_r && DIV_EN) begin
      step_acc_s = {(div_ge_s ? div_diff_s[WIDTH-1:0] : div_trial_s[WIDTH-1:0]),
                    acc_r[WIDTH-2:0], div_ge_s};
    end else begin
      step_acc_s = {mul_add_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction of the finished magnitudes.
  always_comb begin
    prod_s = neg_res_r ? (~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc_r;
    quo_s  = neg_if(acc_r[WIDTH-1:0], neg_res_r);
    rem_s  = neg_if(acc_r[2*WIDTH-1:WIDTH], neg_rem_r);
  end

  // Next-state logic; flush squashes RUN/FIXUP but never a committing DONE.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start_op_s) state_n = RUN;
        else            state_n = IDLE;
      end
      RUN: begin
        if (bus.flush)                      state_n = IDLE;
        else if (count_r == COUNT_W'(1))    state_n = FIXUP;
        else                                state_n = RUN;
      end
      FIXUP: begin
        if (bus.flush) state_n = IDLE;
        else           state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_n;
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r      <= {(2*WIDTH){1'b0}};
      b_r        <= {WIDTH{1'b0}};
      a_raw_r    <= {WIDTH{1'b0}};
      count_r    <= {COUNT_W{1'b0}};
      is_div_r   <= 1'b0;
      neg_res_r  <= 1'b0;
      neg_rem_r  <= 1'b0;
      dbz_flag_r <= 1'b0;
    end else if (start_op_s) begin
      acc_r      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_abs_s : b_abs_s)};
      b_r        <= bus.op[1] ? b_abs_s : a_abs_s;
      a_raw_r    <= bus.rs_data;
      count_r    <= COUNT_W'(WIDTH);
      is_div_r   <= bus.op[1];
      neg_res_r  <= a_neg_s ^ b_neg_s;
      neg_rem_r  <= a_neg_s;
      dbz_flag_r <= (bus.rt_data == {WIDTH{1'b0}});
    end else if (state_r == RUN) begin
      acc_r   <= step_acc_s;
      count_r <= count_r - COUNT_W'(1);
    end else begin
      acc_r   <= acc_r;
      count_r <= count_r;
    end
  end

  // HI/LO commit: MTHI/MTLO from IDLE, arithmetic results on FIXUP->DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (state_r == IDLE && bus.start && !bus.flush && bus.op == 3'd4) begin
      hi_r <= bus.rs_data;
    end else if (state_r == IDLE && bus.start && !bus.flush && bus.op == 3'd5) begin
      lo_r <= bus.rs_data;
    end else if (state_n == DONE) begin
      if (!is_div_r) begin
        hi_r <= prod_s[2*WIDTH-1:WIDTH];
        lo_r <= prod_s[WIDTH-1:0];
      end else if (DIV_EN && dbz_flag_r) begin
        hi_r <= a_raw_r;
        lo_r <= {WIDTH{1'b1}};
      end else if (DIV_EN) begin
        hi_r <= rem_s;
        lo_r <= quo_s;
      end else begin
        hi_r <= hi_r;
        lo_r <= lo_r;
      end
    end else begin
      hi_r <= hi_r;
      lo_r <= lo_r;
    end
  end

  // Registered status flags derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_out_r <= 1'b0;
    end else begin
      busy_r    <= (state_n == RUN) || (state_n == FIXUP);
      done_r    <= (state_n == DONE);
      dbz_out_r <= (state_n == DONE) && is_div_r && dbz_flag_r && DIV_EN;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_out_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.stall       = bus.hilo_read & (busy_r | (bus.start & (bus.op <= 3'd3)));
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed self-checking bench for mips_muldiv_unit (WIDTH=32, divider present).
// Cycle k of an op is the state right after the k-th rising edge following
// the start request (edge 1 samples start).
module tb_mips_muldiv_unit;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  int          done_at, done_cnt, busy_cnt, stall_cnt, dbz_cnt;
  logic [31:0] hi_d, lo_d;
  logic        dbz_d;

  mips_muldiv_unit_if #(.WIDTH(32)) bus_if ();

  mips_muldiv_unit #(.WIDTH(32), .DIV_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one arithmetic op and observe 40 cycles; flush_at>0 squashes it.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at);
    done_at = 0; done_cnt = 0; busy_cnt = 0; stall_cnt = 0; dbz_cnt = 0;
    hi_d = 32'h0; lo_d = 32'h0; dbz_d = 1'b0;
    bus_if.op = o; bus_if.rs_data = a; bus_if.rt_data = b; bus_if.start = 1'b1;
    #1;
    if (bus_if.stall) stall_cnt++;
    for (int k = 1; k <= 40; k++) begin
      tick();
      bus_if.start = 1'b0;
      bus_if.flush = (k == flush_at - 1);
      if (bus_if.busy) busy_cnt++;
      if (bus_if.stall) stall_cnt++;
      if (bus_if.div_by_zero) dbz_cnt++;
      if (bus_if.done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k; hi_d = bus_if.hi; lo_d = bus_if.lo; dbz_d = bus_if.div_by_zero;
        end
      end
    end
    bus_if.flush = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b0;
    bus_if.start = 1'b0; bus_if.op = 3'd0; bus_if.rs_data = 32'h0; bus_if.rt_data = 32'h0;
    bus_if.flush = 1'b0; bus_if.hilo_read = 1'b0;
    #2;
    check("rst_hi", bus_if.hi, 64'h0);
    check("rst_lo", bus_if.lo, 64'h0);
    check("rst_busy", bus_if.busy, 64'h0);
    check("rst_done", bus_if.done, 64'h0);
    check("rst_dbz", bus_if.div_by_zero, 64'h0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // MULT -3 * 5
    run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0);
    check("mult_done_at", done_at, 64'd34);
    check("mult_busy_cycles", busy_cnt, 64'd33);
    check("mult_done_cnt", done_cnt, 64'd1);
    check("mult_hi", hi_d, 64'hFFFF_FFFF);
    check("mult_lo", lo_d, 64'hFFFF_FFF1);
    check("mult_stall", stall_cnt, 64'd0);

    // MULTU max * max
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_hi", hi_d, 64'hFFFF_FFFE);
    check("multu_lo", lo_d, 64'h0000_0001);
    check("multu_done_at", done_at, 64'd34);

    // DIV -7 / 2
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_lo", lo_d, 64'hFFFF_FFFD);
    check("div_hi", hi_d, 64'hFFFF_FFFF);
    check("div_dbz_cnt", dbz_cnt, 64'd0);
    check("div_done_at", done_at, 64'd34);

    // DIV 7 / -2 : remainder follows dividend sign
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 0);
    check("div2_lo", lo_d, 64'hFFFF_FFFD);
    check("div2_hi", hi_d, 64'h0000_0001);

    // DIVU 100 / 0
    run_op(3'd3, 32'd100, 32'd0, 0);
    check("dbz_lo", lo_d, 64'hFFFF_FFFF);
    check("dbz_hi", hi_d, 64'h0000_0064);
    check("dbz_flag", dbz_d, 64'h1);
    check("dbz_cnt", dbz_cnt, 64'd1);
    check("dbz_done_at", done_at, 64'd34);

    // DIV MIN / -1
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_lo", lo_d, 64'h8000_0000);
    check("ovf_hi", hi_d, 64'h0);

    // MTLO, MTHI, and an undefined op
    bus_if.op = 3'd5; bus_if.rs_data = 32'h0000_1234; bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("mtlo_lo", bus_if.lo, 64'h1234);
    check("mtlo_hi", bus_if.hi, 64'h0);
    check("mtlo_busy", bus_if.busy, 64'h0);
    check("mtlo_done", bus_if.done, 64'h0);
    bus_if.op = 3'd4; bus_if.rs_data = 32'h0000_ABCD; bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("mthi_hi", bus_if.hi, 64'hABCD);
    check("mthi_lo", bus_if.lo, 64'h1234);
    bus_if.op = 3'd6; bus_if.rs_data = 32'h0000_5555; bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("op6_hi", bus_if.hi, 64'hABCD);
    check("op6_lo", bus_if.lo, 64'h1234);
    check("op6_busy", bus_if.busy, 64'h0);

    // MULT 7*9 flushed at cycle 10
    run_op(3'd0, 32'd7, 32'd9, 10);
    check("flush_done_cnt", done_cnt, 64'd0);
    check("flush_busy_cycles", busy_cnt, 64'd9);
    check("flush_hi", bus_if.hi, 64'hABCD);
    check("flush_lo", bus_if.lo, 64'h1234);

    // MULT 7*9 with reset asserted at cycle 15
    bus_if.op = 3'd0; bus_if.rs_data = 32'd7; bus_if.rt_data = 32'd9; bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (14) tick();
    check("prerst_busy", bus_if.busy, 64'h1);
    reset = 1'b0;
    #1;
    check("midrst_busy", bus_if.busy, 64'h0);
    check("midrst_hi", bus_if.hi, 64'h0);
    check("midrst_lo", bus_if.lo, 64'h0);
    tick();
    reset = 1'b1;
    tick();

    // MULT 7*9 with MFHI/MFLO waiting the whole time
    bus_if.hilo_read = 1'b1;
    run_op(3'd0, 32'd7, 32'd9, 0);
    check("stall_cycles", stall_cnt, 64'd34);
    check("stall_busy_cycles", busy_cnt, 64'd33);
    check("stall_lo", lo_d, 64'h3F);
    check("stall_hi", hi_d, 64'h0);
    check("stall_idle", bus_if.stall, 64'h0);
    bus_if.hilo_read = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
